fetch_prefetch: RTL and testbench

//  Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue. Issues sequential

---
 rtl/fetch_prefetch_pkg.sv | 21 ++
 rtl/fetch_prefetch_if.sv | 34 +++
 rtl/fetch_prefetch_fifo.sv | 78 +++++++
 rtl/fetch_prefetch.sv | 161 ++++++++++++++++
 tb/tb_fetch_prefetch.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_prefetch_pkg.sv
// Shared constants and types for the fetch/prefetch stage.
//   FP_DATA_WIDTH    default instruction / address width
//   FP_FIRST_ADDR    default PC loaded on reset
//   FP_NOP           default instruction shown while the queue is empty
//   FP_ALIGN_MASK    clears the two low bits of a redirect target
//   redirect_e       which redirect source won this cycle
package fetch_prefetch_pkg;

    localparam int          FP_DATA_WIDTH = 32;
    localparam logic [31:0] FP_FIRST_ADDR = 32'h0000_0000;
    localparam logic [31:0] FP_NOP        = 32'h0000_0013;
    localparam logic [31:0] FP_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_EXC,
        REDIR_BRANCH,
        REDIR_FLUSH
    } redirect_e;

endpackage

// File: rtl/fetch_prefetch_if.sv
// I-cache request/response bundle between the fetch stage and the I-cache.
//   cache_req_out   fetch request valid (fetch -> cache)
//   cache_addr_out  fetch address       (fetch -> cache)
//   cache_ready     cache takes the request this cycle (cache -> fetch)
//   cache_in        returned instruction                (cache -> fetch)
//   cache_valid     response valid, in order, >=1 cycle after acceptance
// Handshake: a request transfers on a cycle where cache_req_out && cache_ready;
// until then the fetch side holds cache_req_out and cache_addr_out stable
// unless a redirect withdraws the request.
interface fetch_prefetch_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  cache_req_out;
    logic [DATA_WIDTH-1:0] cache_addr_out;
    logic                  cache_ready;
    logic [DATA_WIDTH-1:0] cache_in;
    logic                  cache_valid;

    modport master (
        output cache_req_out,
        output cache_addr_out,
        input  cache_ready,
        input  cache_in,
        input  cache_valid
    );

    modport slave (
        input  cache_req_out,
        input  cache_addr_out,
        output cache_ready,
        output cache_in,
        output cache_valid
    );
endinterface

// File: rtl/fetch_prefetch_fifo.sv
// fetch_fifo: synchronous FIFO holding {pc, instr} entries for decode.
//   clk, rst     clock, asynchronous active-high reset
//   clear_i      drop every entry (wins over push/pop)
//   push_i/din_i write an entry
//   pop_i        retire the head entry
//   dout_o       head entry, read combinationally
//   full_o, empty_o, count_o  occupancy status
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (!push_i && pop_i) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push_i && full_o && !pop_i && !clear_i))
                else $error("fetch_fifo: push into full queue");
            assert (!(pop_i && empty_o && !clear_i))
                else $error("fetch_fifo: pop from empty queue");
        end
    end
endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction-fetch stage with a DEPTH-entry prefetch queue.
//   clk, reset                 clock, asynchronous active-high reset
//   stall                      decode cannot take the head this cycle
//   flush                      drop queue + in-flight fetches, refetch oldest lost PC
//   exception / exception_handler_address   highest-priority redirect
//   branch / branch_target                  second-priority redirect
//   cache (fetch_prefetch_if.master)        I-cache request/response
//   instruction_out, instruction_address_out, pc_plus_4_out,
//   instruction_valid_out      queue head presented to decode
// Queued entries plus in-flight requests never exceed DEPTH, so every
// response always has a slot waiting for it.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = FP_DATA_WIDTH,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR = FP_FIRST_ADDR,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = FP_NOP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  exception,
    input  logic [DATA_WIDTH-1:0] exception_handler_address,
    input  logic                  branch,
    input  logic [DATA_WIDTH-1:0] branch_target,
    fetch_prefetch_if.master      cache,
    output logic [DATA_WIDTH-1:0] instruction_out,
    output logic [DATA_WIDTH-1:0] instruction_address_out,
    output logic [DATA_WIDTH-1:0] pc_plus_4_out,
    output logic                  instruction_valid_out
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(~FP_ALIGN_MASK);
    localparam logic [CW:0]           CAP        = (CW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;

    logic [EW-1:0]         fifo_head;
    logic [DATA_WIDTH-1:0] head_pc, head_instr;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_push, fifo_pop;

    redirect_e             redir_kind;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redir_raw, redir_target;
    logic [CW:0]           in_use;
    logic                  accept, resp_drop;

    assign head_pc    = fifo_head[EW-1:DATA_WIDTH];
    assign head_instr = fifo_head[DATA_WIDTH-1:0];

    // Flush restarts at the oldest PC decode has not consumed: the queue head
    // if anything is queued, otherwise the PC of the next expected response.
    always_comb begin
        redir_kind = REDIR_NONE;
        redir_raw  = resp_pc_q;
        if (exception) begin
            redir_kind = REDIR_EXC;
            redir_raw  = exception_handler_address;
        end else if (branch) begin
            redir_kind = REDIR_BRANCH;
            redir_raw  = branch_target;
        end else if (flush) begin
            redir_kind = REDIR_FLUSH;
            redir_raw  = fifo_empty ? resp_pc_q : head_pc;
        end
    end

    assign redirect     = (redir_kind != REDIR_NONE);
    assign redir_target = redir_raw & ALIGN_MASK;

    // Credit: a new request only when the queue can absorb every fetch in flight.
    assign in_use              = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign cache.cache_req_out  = !reset && !redirect && (in_use < CAP);
    assign cache.cache_addr_out = fetch_pc_q;
    assign accept               = cache.cache_req_out && cache.cache_ready;

    // Responses for fetches issued before a redirect are stale while drop_cnt_q > 0.
    assign resp_drop = cache.cache_valid && (drop_cnt_q != '0);
    assign fifo_push = cache.cache_valid && (drop_cnt_q == '0) && !redirect;
    assign fifo_pop  = !fifo_empty && !stall && !redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        if (accept && !cache.cache_valid)      outstanding_d = outstanding_q + 1'b1;
        else if (!accept && cache.cache_valid) outstanding_d = outstanding_q - 1'b1;

        if (accept)    fetch_pc_d = fetch_pc_q + PC_STEP;
        if (resp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
        if (fifo_push) resp_pc_d  = resp_pc_q + PC_STEP;

        // Every fetch still in flight after this edge belongs to the old path;
        // drop_cnt_q counts the stale subset of outstanding_q, so it becomes
        // the whole remaining in-flight count (already-stale ones included).
        if (redirect) begin
            fetch_pc_d = redir_target;
            resp_pc_d  = redir_target;
            drop_cnt_d = outstanding_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_ADDR;
            resp_pc_q     <= RESET_ADDR;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .clear_i (redirect),
        .push_i  (fifo_push),
        .din_i   ({resp_pc_q, cache.cache_in}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign instruction_valid_out   = !fifo_empty;
    assign instruction_out         = fifo_empty ? NOP_INSTR : head_instr;
    assign instruction_address_out = fifo_empty ? resp_pc_q : head_pc;
    assign pc_plus_4_out           = instruction_address_out + PC_STEP;

    always @(posedge clk) begin
        if (!reset) begin
            assert (outstanding_q <= CW'(DEPTH))
                else $error("fetch_prefetch: outstanding above DEPTH");
            assert (drop_cnt_q <= outstanding_q)
                else $error("fetch_prefetch: drop_cnt above outstanding");
            assert (!(cache.cache_valid && outstanding_q == '0))
                else $error("fetch_prefetch: response with nothing outstanding");
            assert (!(fifo_push && fifo_full && !fifo_pop))
                else $error("fetch_prefetch: queue overflow");
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] RST_ADDR  = 32'h0000_1000;
    localparam logic [31:0] NOP_VAL   = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, exception, branch;
    logic [31:0] exception_handler_address, branch_target;
    logic [31:0] instruction_out, instruction_address_out, pc_plus_4_out;
    logic        instruction_valid_out;

    always #5 clk = ~clk;

    fetch_prefetch_if #(.DATA_WIDTH(32)) cif ();

    fetch_prefetch #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_ADDR (RST_ADDR),
        .NOP_INSTR  (NOP_VAL)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .stall                     (stall),
        .flush                     (flush),
        .exception                 (exception),
        .exception_handler_address (exception_handler_address),
        .branch                    (branch),
        .branch_target             (branch_target),
        .cache                     (cif),
        .instruction_out           (instruction_out),
        .instruction_address_out   (instruction_address_out),
        .pc_plus_4_out             (pc_plus_4_out),
        .instruction_valid_out     (instruction_valid_out)
    );

    // ---------------- scoreboard state ----------------
    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    int          lat     = 1;
    logic [31:0] exp_q[$];       // PCs decode should see, in order
    logic [31:0] infl_addr[$];   // fetches accepted by the cache, oldest first
    int          infl_due[$];
    bit          infl_stale[$];
    logic [31:0] exp_fetch;

    function automatic logic [31:0] fn_instr(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // PC decode would have seen next had nothing been thrown away.
    function automatic logic [31:0] oldest_pc();
        if (exp_q.size() != 0) return exp_q[0];
        foreach (infl_stale[i]) if (!infl_stale[i]) return infl_addr[i];
        return exp_fetch;
    endfunction

    task automatic compare_outputs();
        logic redir, exp_req;
        redir = exception | branch | flush;
        chk("valid", {31'd0, instruction_valid_out}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("head_pc", instruction_address_out, exp_q[0]);
            chk("head_instr", instruction_out, fn_instr(exp_q[0]));
            chk("pc_plus_4", pc_plus_4_out, exp_q[0] + 32'd4);
        end else begin
            chk("idle_instr", instruction_out, NOP_VAL);
        end
        exp_req = !redir && ((exp_q.size() + infl_addr.size()) < DEPTH);
        chk("req", {31'd0, cif.cache_req_out}, {31'd0, exp_req});
        if (exp_req) chk("req_addr", cif.cache_addr_out, exp_fetch);
    endtask

    task automatic model_update();
        logic        redir;
        logic [31:0] tgt, a;
        bit          s;
        int          d;
        if (reset) begin
            exp_q.delete(); infl_addr.delete(); infl_due.delete(); infl_stale.delete();
            exp_fetch = RST_ADDR;
            cyc++;
            return;
        end
        redir = exception | branch | flush;
        if (exception)   tgt = exception_handler_address;
        else if (branch) tgt = branch_target;
        else             tgt = oldest_pc();
        tgt[1:0] = 2'b00;
        if (exp_q.size() != 0 && !stall && !redir) void'(exp_q.pop_front());
        if (cif.cache_valid && infl_addr.size() != 0) begin
            a = infl_addr.pop_front();
            s = infl_stale.pop_front();
            d = infl_due.pop_front();
            if (!s && !redir) exp_q.push_back(a);
        end
        if (cif.cache_req_out && cif.cache_ready) begin
            infl_addr.push_back(exp_fetch);
            infl_due.push_back(cyc + lat);
            infl_stale.push_back(1'b0);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            foreach (infl_stale[i]) infl_stale[i] = 1'b1;
            exp_fetch = tgt;
        end
        cyc++;
    endtask

    // Compare on the falling edge, advance the model just before the rising edge.
    always begin
        @(negedge clk);
        if (!reset) compare_outputs();
        #3;
        model_update();
    end

    // Cache responder: returns accepted fetches in order after `lat` cycles.
    initial begin
        cif.cache_valid = 1'b0;
        cif.cache_in    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (infl_addr.size() != 0 && infl_due[0] <= cyc) begin
                cif.cache_valid = 1'b1;
                cif.cache_in    = fn_instr(infl_addr[0]);
            end else begin
                cif.cache_valid = 1'b0;
                cif.cache_in    = '0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            if (instruction_valid_out) break;
            tick(1);
            #2;
        end
        if (i == max_cycles) chk(name, 32'd0, 32'd1);
    endtask

    logic [31:0] acc_addr[$];

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; exception = 1'b0; branch = 1'b0;
        exception_handler_address = '0; branch_target = '0;
        cif.cache_ready = 1'b1;
        lat = 1;

        // Reset values
        tick(2); #2;
        chk("rst_req", {31'd0, cif.cache_req_out}, 32'd0);
        chk("rst_valid", {31'd0, instruction_valid_out}, 32'd0);
        chk("rst_instr", instruction_out, NOP_VAL);
        chk("rst_addr", instruction_address_out, RST_ADDR);
        chk("rst_pc4", pc_plus_4_out, RST_ADDR + 32'd4);
        reset = 1'b0;

        // 1: streaming fetch, 1-cycle latency
        tick(2); #2;
        chk("t1_first_pc", instruction_address_out, 32'h0000_1000);
        tick(1); #2;
        chk("t1_second_pc", instruction_address_out, 32'h0000_1004);
        tick(1); #2;
        chk("t1_third_instr", instruction_out, fn_instr(32'h0000_1008));
        tick(8);

        // 2: decode stalled, queue fills, requests stop
        stall = 1'b1;
        tick(10); #2;
        chk("t2_req_full", {31'd0, cif.cache_req_out}, 32'd0);
        chk("t2_valid_full", {31'd0, instruction_valid_out}, 32'd1);
        tick(1);
        stall = 1'b0;
        tick(12);

        // 3: branch with three fetches in flight
        reset = 1'b1;
        tick(2);
        reset = 1'b0; lat = 4;
        tick(3);
        branch = 1'b1; branch_target = 32'h0000_0100;
        tick(1);
        branch = 1'b0; #2;
        chk("t3_valid_after", {31'd0, instruction_valid_out}, 32'd0);
        chk("t3_req_addr", cif.cache_addr_out, 32'h0000_0100);
        wait_valid("t3_wait_valid", 40);
        chk("t3_first_pc", instruction_address_out, 32'h0000_0100);
        tick(6);

        // 4: exception beats branch
        lat = 1;
        exception = 1'b1; exception_handler_address = 32'h0000_0204;
        branch = 1'b1; branch_target = 32'h0000_0300;
        tick(1);
        exception = 1'b0; branch = 1'b0; #2;
        chk("t4_req_addr", cif.cache_addr_out, 32'h0000_0204);
        chk("t4_valid_after", {31'd0, instruction_valid_out}, 32'd0);
        wait_valid("t4_wait_valid", 20);
        chk("t4_first_pc", instruction_address_out, 32'h0000_0204);
        tick(4);

        // 5: flush with queue {0x20, 0x24}, then unaligned branch target
        stall = 1'b1;
        branch = 1'b1; branch_target = 32'h0000_0020;
        tick(1);
        branch = 1'b0;
        tick(2);
        cif.cache_ready = 1'b0;
        tick(3); #2;
        chk("t5_head_before", instruction_address_out, 32'h0000_0020);
        flush = 1'b1;
        tick(1);
        flush = 1'b0; #2;
        chk("t5_valid_after", {31'd0, instruction_valid_out}, 32'd0);
        chk("t5_refetch_addr", cif.cache_addr_out, 32'h0000_0020);
        tick(1);
        branch = 1'b1; branch_target = 32'h0000_0103;
        tick(1);
        branch = 1'b0; stall = 1'b0; cif.cache_ready = 1'b1; #2;
        chk("t5_aligned_addr", cif.cache_addr_out, 32'h0000_0100);
        wait_valid("t5_wait_valid", 20);
        chk("t5_first_pc", instruction_address_out, 32'h0000_0100);
        tick(4);

        // 6: address wrap, then async reset mid-run
        branch = 1'b1; branch_target = 32'hFFFF_FFF8;
        tick(1);
        branch = 1'b0;
        for (int i = 0; i < 10 && acc_addr.size() < 4; i++) begin
            #2;
            if (cif.cache_req_out && cif.cache_ready) acc_addr.push_back(cif.cache_addr_out);
            tick(1);
        end
        if (acc_addr.size() != 4) chk("t6_accept_count", acc_addr.size(), 32'd4);
        else begin
            chk("t6_addr0", acc_addr[0], 32'hFFFF_FFF8);
            chk("t6_addr1", acc_addr[1], 32'hFFFF_FFFC);
            chk("t6_addr2", acc_addr[2], 32'h0000_0000);
            chk("t6_addr3", acc_addr[3], 32'h0000_0004);
        end
        stall = 1'b1;
        tick(3);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, instruction_valid_out}, 32'd0);
        chk("t6_rst_req", {31'd0, cif.cache_req_out}, 32'd0);
        chk("t6_rst_instr", instruction_out, NOP_VAL);
        chk("t6_rst_addr", instruction_address_out, RST_ADDR);
        tick(2);
        reset = 1'b0; stall = 1'b0;
        tick(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
